// File: rtl/line_data_memory_if.sv
// Line-transfer bus between the data cache (master) and the line memory (slave).
// Names follow the memory's point of view: *_i driven by the cache, *_o by the memory.
interface line_data_memory_if #(
  parameter int LINE_BITS = 256
);
  logic [31:0]          addr_i;
  logic [LINE_BITS-1:0] data_i;
  logic                 enable_i;
  logic                 write_i;
  logic                 ack_o;
  logic [LINE_BITS-1:0] data_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/line_data_memory.sv
// Off-chip line memory behind the data cache: one outstanding 256-bit line
// read or write, acknowledged a fixed LATENCY cycles after acceptance.
module line_data_memory #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH     = 512,
  parameter int LATENCY   = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  line_data_memory_if.slave  bus
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [8:0]  LAT_C = 9'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]           r_state;
  logic [7:0]           r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [LINE_BITS-1:0] r_wdata;
  logic                 r_write;
  logic                 r_ack;
  logic [LINE_BITS-1:0] r_rdata;
  logic [LINE_BITS-1:0] r_mem [DEPTH];

  logic [8:0]           w_cnt_nxt;
  logic                 w_fire;
  logic [IDX_W-1:0]     w_idx;
  logic [LINE_BITS-1:0] w_wdata;
  logic                 w_write;
  logic                 w_unused_addr;

  assign w_cnt_nxt = {1'b0, r_cnt} + 9'd1;

  // The access happens on the edge that moves into ACK; with LATENCY=1 that is
  // the acceptance edge itself, so the request fields come straight from the bus.
  assign w_fire = ((r_state == S_IDLE) && bus.enable_i && (LATENCY == 1)) ||
                  ((r_state == S_WAIT) && (w_cnt_nxt == LAT_C));

  assign w_idx   = (r_state == S_IDLE) ? bus.addr_i[5 +: IDX_W] : r_idx;
  assign w_wdata = (r_state == S_IDLE) ? bus.data_i             : r_wdata;
  assign w_write = (r_state == S_IDLE) ? bus.write_i            : r_write;

  assign w_unused_addr = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};

  assign bus.ack_o  = r_ack;
  assign bus.data_o = r_rdata;

  // Array contents survive reset; a reset edge suppresses a write that would land on it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_fire && w_write) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_fire;
      if (w_fire && !w_write) begin
        r_rdata <= r_mem[w_idx];
      end
      case (r_state)
        S_IDLE: begin
          if (bus.enable_i) begin
            r_idx   <= bus.addr_i[5 +: IDX_W];
            r_wdata <= bus.data_i;
            r_write <= bus.write_i;
            r_cnt   <= 8'd1;
            r_state <= (LATENCY == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt[7:0];
          if (w_fire) begin
            r_state <= S_ACK;
          end
        end
        // Enable is still high here; leaving unconditionally keeps it from being re-accepted.
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_data_memory.sv
// Directed bench for line_data_memory: two instances (LATENCY 10 and 1) checked
// every cycle against a transaction-level model plus literal expectations.
module tb_line_data_memory;
  localparam int LB = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_data_memory_if #(.LINE_BITS(LB)) if0 ();
  line_data_memory_if #(.LINE_BITS(LB)) if1 ();

  line_data_memory #(.LINE_BITS(LB), .DEPTH(512), .LATENCY(10)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0.slave)
  );

  line_data_memory #(.LINE_BITS(LB), .DEPTH(512), .LATENCY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int u);
    return (u == 0) ? if0.ack_o : if1.ack_o;
  endfunction

  function automatic logic [LB-1:0] data_of(input int u);
    return (u == 0) ? if0.data_o : if1.data_o;
  endfunction

  // Transaction model: a request accepted at edge n completes at edge n+L-1
  // (ack visible for the following cycle) and the unit is free again after edge n+L.
  logic [LB-1:0] mm [2][512];
  bit            busy [2];
  int            done_e [2];
  bit            m_wr [2];
  int            m_idx [2];
  logic [LB-1:0] m_wd [2];
  logic          ack_e [2];
  logic [LB-1:0] dat_e [2];
  bit            m_valid = 0;
  int            ncyc = 0;
  logic          s_en;
  logic          s_wr;
  logic [31:0]   s_adr;
  logic [LB-1:0] s_wd;
  int            s_lat;

  always begin
    @(posedge clk);
    ncyc++;
    for (int u = 0; u < 2; u++) begin
      s_en  = (u == 0) ? if0.enable_i : if1.enable_i;
      s_wr  = (u == 0) ? if0.write_i  : if1.write_i;
      s_adr = (u == 0) ? if0.addr_i   : if1.addr_i;
      s_wd  = (u == 0) ? if0.data_i   : if1.data_i;
      s_lat = (u == 0) ? 10 : 1;
      if (rst) begin
        busy[u]  = 0;
        ack_e[u] = 1'b0;
        dat_e[u] = '0;
      end else begin
        ack_e[u] = 1'b0;
        if (busy[u] && ncyc == done_e[u]) begin
          busy[u] = 0;
        end else if (!busy[u] && s_en) begin
          busy[u]   = 1;
          done_e[u] = ncyc + s_lat;
          m_idx[u]  = int'(s_adr[13:5]);
          m_wr[u]   = s_wr;
          m_wd[u]   = s_wd;
        end
        if (busy[u] && ncyc == done_e[u] - 1) begin
          if (m_wr[u]) mm[u][m_idx[u]] = m_wd[u];
          else         dat_e[u] = mm[u][m_idx[u]];
          ack_e[u] = 1'b1;
        end
      end
    end
    if (rst) m_valid = 1;
    @(negedge clk);
    if (m_valid) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("model_ack_u%0d_cyc%0d", u, ncyc), LB'(ack_of(u)), LB'(ack_e[u]));
        chk($sformatf("model_data_u%0d_cyc%0d", u, ncyc), data_of(u), dat_e[u]);
      end
    end
  end

  task automatic drive(input int u, input logic en, input logic w,
                       input logic [31:0] a, input logic [LB-1:0] d);
    if (u == 0) begin
      if0.enable_i = en; if0.write_i = w; if0.addr_i = a; if0.data_i = d;
    end else begin
      if1.enable_i = en; if1.write_i = w; if1.addr_i = a; if1.data_i = d;
    end
  endtask

  // Full handshake: hold enable until ack (bounded), then release it.
  task automatic xact(input int u, input logic w, input logic [31:0] a,
                      input logic [LB-1:0] d, output logic [LB-1:0] rd);
    bit got;
    got = 0;
    drive(u, 1'b1, w, a, d);
    @(posedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack_of(u)) begin
        got = 1;
        break;
      end
    end
    chk("xact_ack_seen", LB'(got), LB'(1));
    rd = data_of(u);
    drive(u, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
  endtask

  // Called right after the acceptance edge: ack must be low for lat-1 cycles, then high.
  task automatic lat_expect(input int u, input int lat, input string nm);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk({nm, "_early"}, LB'(ack_of(u)), LB'(0));
    end
    @(negedge clk);
    chk({nm, "_ack"}, LB'(ack_of(u)), LB'(1));
  endtask

  localparam logic [LB-1:0] P5  = {8{32'h0505_0505}};
  localparam logic [LB-1:0] P7  = {8{32'h7777_0007}};
  localparam logic [LB-1:0] P9  = {8{32'h9999_0009}};
  localparam logic [LB-1:0] P2  = {8{32'h2222_0002}};
  localparam logic [LB-1:0] PA5 = {32{8'hA5}};
  localparam logic [LB-1:0] PW  = {4{64'hDEAD_BEEF_0000_01FF}};
  localparam logic [LB-1:0] PB  = {8{32'hBEEF_0001}};

  logic [LB-1:0] rd;

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    drive(1, 1'b0, 1'b0, 32'h0, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Preload lines through the bus
    xact(0, 1'b1, 32'h0000_00A0, P5, rd);
    xact(0, 1'b1, 32'h0000_0060, PA5, rd);
    xact(0, 1'b1, 32'h0000_00E0, P7, rd);
    xact(0, 1'b1, 32'h0000_0120, P9, rd);
    xact(0, 1'b1, 32'h0000_0040, P2, rd);

    // Reset held three cycles with enable low
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ack", LB'(if0.ack_o), LB'(0));
      chk("rst_data", if0.data_o, '0);
    end
    rst = 1'b0;
    xact(0, 1'b0, 32'h0000_00A0, '0, rd);
    chk("rst_keeps_array5", rd, P5);

    // Read idx 3 with exact latency, no second ack
    drive(0, 1'b1, 1'b0, 32'h0000_0060, '0);
    @(posedge clk);
    lat_expect(0, 10, "read3");
    chk("read3_data", if0.data_o, PA5);
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    chk("read3_ack_t11", LB'(if0.ack_o), LB'(0));
    chk("read3_data_held", if0.data_o, PA5);

    // Write idx 4 then read it back-to-back
    drive(0, 1'b1, 1'b1, 32'h0000_0080, LB'(256'h1234));
    @(posedge clk);
    lat_expect(0, 10, "wr4");
    chk("wr4_data_unchanged", if0.data_o, PA5);
    drive(0, 1'b1, 1'b0, 32'h0000_0080, '0);
    @(posedge clk);
    @(negedge clk);
    chk("wr4_ack_one_cycle", LB'(if0.ack_o), LB'(0));
    @(posedge clk);
    lat_expect(0, 10, "rd4");
    chk("rd4_data", if0.data_o, LB'(256'h1234));
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);

    // Input changes during WAIT are ignored
    drive(0, 1'b1, 1'b0, 32'h0000_00E0, '0);
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) drive(0, 1'b1, 1'b1, 32'h0000_0120, {8{32'hFFFF_FFFF}});
      if (i == 4) if0.enable_i = 1'b0;
      if (i < 10) chk("glitch_early", LB'(if0.ack_o), LB'(0));
      else begin
        chk("glitch_ack", LB'(if0.ack_o), LB'(1));
        chk("glitch_data", if0.data_o, P7);
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    xact(0, 1'b0, 32'h0000_0120, '0, rd);
    chk("glitch_array9", rd, P9);

    // Reset mid-operation aborts a write to idx 2
    drive(0, 1'b1, 1'b1, 32'h0000_0040, {8{32'hBAD0_BAD0}});
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, '0);
      end
      if (i == 4) rst = 1'b0;
      chk("abort_no_ack", LB'(if0.ack_o), LB'(0));
    end
    drive(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    @(posedge clk);
    lat_expect(0, 10, "after_rst");
    chk("abort_array2", if0.data_o, P2);
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);

    // Address wrap: idx 511 aliased by upper bits
    xact(0, 1'b1, 32'h0000_3FE0, PW, rd);
    xact(0, 1'b0, 32'h0000_7FE0, '0, rd);
    chk("wrap_data", rd, PW);

    // LATENCY=1 instance
    drive(1, 1'b1, 1'b1, 32'h0000_00A0, PB);
    @(posedge clk);
    lat_expect(1, 1, "l1_wr");
    drive(1, 1'b1, 1'b0, 32'h0000_00A0, '0);
    @(negedge clk);
    chk("l1_ack_one_cycle", LB'(if1.ack_o), LB'(0));
    @(posedge clk);
    lat_expect(1, 1, "l1_rd");
    chk("l1_rd_data", if1.data_o, PB);
    drive(1, 1'b0, 1'b0, 32'h0, '0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
